// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage of the pipelined RISC15 core. It takes the EX/MEM register
//   and produces the MEM/WB register. Non-memory ops pass through with one
//   cycle of latency. LW/SW perform one handshaked data-memory access. LM/SM
//   walk the 8-bit register list in ascending order, one access per listed
//   register, while stalling upstream.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_*                       EX/MEM register contents (sampled only in IDLE)
//   stall_out                  upstream must hold while a memory op is active
//   dmem_*                     data-memory request/response handshake
//   rf_rd_addr / rf_rd_data    register-file read port used by SM
//   out_*                      MEM/WB register contents
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting a new instruction from EX/MEM
// ACCESS | single LW/SW access outstanding, waiting for dmem_ready
// MULTI  | LM/SM in progress, one access per remaining list bit
module mem_access_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [5:0]        in_op,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_ra_data,
  input  logic [2:0]        in_dest,
  input  logic              in_reg_write,
  input  logic              in_ccr_write,
  input  logic [1:0]        in_ccr_value,
  input  logic [7:0]        in_imm8,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  output logic [2:0]        out_dest,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_reg_write,
  output logic              out_ccr_write,
  output logic [1:0]        out_ccr_value,
  output logic              out_zero_write,
  output logic              out_zero_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MULTI  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [7:0]         list_q, list_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  wdata_q, wdata_n;
  logic               we_q, we_n;
  logic [2:0]         dest_q, dest_n;

  logic               o_valid_n;
  logic [2:0]         o_dest_n;
  logic [DATA_W-1:0]  o_wdata_n;
  logic               o_rw_n;
  logic               o_ccrw_n;
  logic [1:0]         o_ccrv_n;
  logic               o_zw_n;
  logic               o_zv_n;

  logic [3:0]         op;
  logic               is_mem;
  logic [2:0]         k;

  // IR[1:0] travels with the opcode but has no meaning in this stage.
  logic               unused_op_bits;
  assign unused_op_bits = ^in_op[1:0];

  assign op     = in_op[5:2];
  assign is_mem = (op[3:2] == 2'b01);

  // Lowest set bit of the remaining list gives ascending register order.
  always_comb begin
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (list_q[i]) k = 3'(i);
    end
  end

  assign stall_out  = (state_q != IDLE);
  assign dmem_req   = (state_q != IDLE);
  assign dmem_we    = (state_q != IDLE) && we_q;
  assign dmem_addr  = addr_q;
  // SM data comes straight from the register file for the current list bit.
  assign dmem_wdata = (state_q == MULTI) ? rf_rd_data : wdata_q;
  assign rf_rd_addr = (state_q == MULTI) ? k : 3'd0;

  always_comb begin
    state_n   = state_q;
    list_n    = list_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    we_n      = we_q;
    dest_n    = dest_q;
    o_valid_n = 1'b0;
    o_dest_n  = 3'd0;
    o_wdata_n = '0;
    o_rw_n    = 1'b0;
    o_ccrw_n  = 1'b0;
    o_ccrv_n  = 2'b00;
    o_zw_n    = 1'b0;
    o_zv_n    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            o_valid_n = 1'b1;
            o_dest_n  = in_dest;
            o_wdata_n = in_alu_out;
            o_rw_n    = in_reg_write;
            o_ccrw_n  = in_ccr_write;
            o_ccrv_n  = in_ccr_value;
          end else if (!op[1]) begin
            addr_n  = ADDR_W'(in_alu_out);
            wdata_n = in_ra_data;
            we_n    = op[0];
            dest_n  = in_dest;
            state_n = ACCESS;
          end else if (in_imm8 != 8'd0) begin
            list_n  = in_imm8;
            addr_n  = ADDR_W'(in_alu_out);
            we_n    = op[0];
            state_n = MULTI;
          end else begin
            // Empty LM/SM list retires as a NOP.
            o_valid_n = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (dmem_ready) begin
          o_valid_n = 1'b1;
          if (!we_q) begin
            o_dest_n  = dest_q;
            o_wdata_n = dmem_rdata;
            o_rw_n    = 1'b1;
            o_zw_n    = 1'b1;
            o_zv_n    = (dmem_rdata == '0);
          end
          state_n = IDLE;
        end
      end

      MULTI: begin
        if (dmem_ready) begin
          o_valid_n = 1'b1;
          if (!we_q) begin
            o_dest_n  = k;
            o_wdata_n = dmem_rdata;
            o_rw_n    = 1'b1;
          end
          // x & (x-1) clears exactly the lowest set bit, i.e. bit k.
          list_n = list_q & (list_q - 8'd1);
          addr_n = addr_q + ADDR_W'(1);
          if ((list_q & (list_q - 8'd1)) == 8'd0) state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      list_q         <= 8'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      dest_q         <= 3'd0;
      out_valid      <= 1'b0;
      out_dest       <= 3'd0;
      out_wdata      <= '0;
      out_reg_write  <= 1'b0;
      out_ccr_write  <= 1'b0;
      out_ccr_value  <= 2'b00;
      out_zero_write <= 1'b0;
      out_zero_value <= 1'b0;
    end else begin
      state_q        <= state_n;
      list_q         <= list_n;
      addr_q         <= addr_n;
      wdata_q        <= wdata_n;
      we_q           <= we_n;
      dest_q         <= dest_n;
      out_valid      <= o_valid_n;
      out_dest       <= o_dest_n;
      out_wdata      <= o_wdata_n;
      out_reg_write  <= o_rw_n;
      out_ccr_write  <= o_ccrw_n;
      out_ccr_value  <= o_ccrv_n;
      out_zero_write <= o_zw_n;
      out_zero_value <= o_zv_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [15:0] in_alu_out;
  logic [15:0] in_ra_data;
  logic [2:0]  in_dest;
  logic        in_reg_write;
  logic        in_ccr_write;
  logic [1:0]  in_ccr_value;
  logic [7:0]  in_imm8;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        out_valid;
  logic [2:0]  out_dest;
  logic [15:0] out_wdata;
  logic        out_reg_write;
  logic        out_ccr_write;
  logic [1:0]  out_ccr_value;
  logic        out_zero_write;
  logic        out_zero_value;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_alu_out(in_alu_out), .in_ra_data(in_ra_data), .in_dest(in_dest),
    .in_reg_write(in_reg_write), .in_ccr_write(in_ccr_write),
    .in_ccr_value(in_ccr_value), .in_imm8(in_imm8), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
    .out_dest(out_dest), .out_wdata(out_wdata), .out_reg_write(out_reg_write),
    .out_ccr_write(out_ccr_write), .out_ccr_value(out_ccr_value),
    .out_zero_write(out_zero_write), .out_zero_value(out_zero_value)
  );

  // Bench-side register file and data memory.
  logic [15:0] rf [8];
  assign rf_rd_data = rf[rf_rd_addr];
  logic [15:0] mem [logic [15:0]];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } tx_t;

  typedef struct {
    logic        full;   // dest and wdata are meaningful
    logic [2:0]  dest;
    logic [15:0] wdata;
    logic        rw;
    logic        ccrw;
    logic [1:0]  ccrv;
    logic        zw;
    logic        zv;
  } out_t;

  tx_t  tx_q[$];
  out_t out_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LM) || (op == OP_SM);
  endfunction

  // Reference model: the memory transactions and MEM/WB entries an
  // instruction must produce, in order.
  task automatic model(input logic [3:0] op, input logic [15:0] alu,
                       input logic [15:0] ra, input logic [2:0] dest,
                       input logic rw, input logic ccrw, input logic [1:0] ccrv,
                       input logic [7:0] imm8);
    out_t o;
    tx_t  t;
    logic [15:0] a;
    o = '{full: 1'b0, dest: 3'd0, wdata: 16'h0, rw: 1'b0, ccrw: 1'b0,
          ccrv: 2'b00, zw: 1'b0, zv: 1'b0};
    if (!is_mem_op(op)) begin
      o.full = 1'b1; o.dest = dest; o.wdata = alu;
      o.rw = rw; o.ccrw = ccrw; o.ccrv = ccrv;
      out_q.push_back(o);
    end else if (op == OP_LW) begin
      t = '{we: 1'b0, addr: alu, wdata: 16'h0};
      tx_q.push_back(t);
      o.full = 1'b1; o.dest = dest; o.wdata = mem_rd(alu); o.rw = 1'b1;
      o.zw = 1'b1; o.zv = (mem_rd(alu) == 16'h0);
      out_q.push_back(o);
    end else if (op == OP_SW) begin
      t = '{we: 1'b1, addr: alu, wdata: ra};
      tx_q.push_back(t);
      out_q.push_back(o);
    end else begin
      a = alu;
      for (int i = 0; i < 8; i++) begin
        if (imm8[i]) begin
          t = '{we: (op == OP_SM), addr: a, wdata: rf[i]};
          tx_q.push_back(t);
          o.full = (op == OP_LM); o.rw = (op == OP_LM);
          o.dest = 3'(i); o.wdata = mem_rd(a);
          out_q.push_back(o);
          a = a + 16'd1;
        end
      end
      if (imm8 == 8'd0) out_q.push_back(o);
    end
  endtask

  // Issues one instruction, plays the memory, and compares everything the DUT
  // does against the model queues. delay<0 picks random ready latency.
  // abort_at>=0 asserts reset instead of completing that transfer.
  task automatic run_instr(input logic [3:0] op, input logic [15:0] alu,
                           input logic [15:0] ra, input logic [2:0] dest,
                           input logic rw, input logic ccrw,
                           input logic [1:0] ccrv, input logic [7:0] imm8,
                           input int delay, input int abort_at,
                           output int req_cycles);
    int   done = 0;
    int   wait_cnt = 0;
    int   cur_delay = 0;
    int   budget = 0;
    logic aborted = 1'b0;
    out_t o;
    tx_t  t;
    req_cycles = 0;
    model(op, alu, ra, dest, rw, ccrw, ccrv, imm8);
    @(negedge clk);
    in_valid = 1'b1; in_op = {op, 2'($urandom)}; in_alu_out = alu;
    in_ra_data = ra; in_dest = dest; in_reg_write = rw;
    in_ccr_write = ccrw; in_ccr_value = ccrv; in_imm8 = imm8;
    @(negedge clk);
    in_valid = 1'b0;
    in_alu_out = 16'($urandom); in_ra_data = 16'($urandom);
    in_dest = 3'($urandom); in_imm8 = 8'($urandom);
    while (budget < 300) begin
      if (out_valid) begin
        checks++;
        if (out_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: out_valid=%b required 0", out_valid);
        end else begin
          o = out_q.pop_front();
          if (out_reg_write !== o.rw || out_ccr_write !== o.ccrw ||
              out_zero_write !== o.zw ||
              (o.ccrw && out_ccr_value !== o.ccrv) ||
              (o.zw && out_zero_value !== o.zv) ||
              (o.full && (out_dest !== o.dest || out_wdata !== o.wdata))) begin
            failures++;
            $display("FAIL out_entry: got rw=%b ccrw=%b ccrv=%b zw=%b zv=%b dest=%0d wdata=%h required rw=%b ccrw=%b ccrv=%b zw=%b zv=%b dest=%0d wdata=%h",
                     out_reg_write, out_ccr_write, out_ccr_value, out_zero_write,
                     out_zero_value, out_dest, out_wdata, o.rw, o.ccrw, o.ccrv,
                     o.zw, o.zv, o.dest, o.wdata);
          end
        end
      end
      checks++;
      if (stall_out !== (tx_q.size() != 0)) begin
        failures++;
        $display("FAIL stall: got %b required %b", stall_out, tx_q.size() != 0);
      end
      if (tx_q.size() == 0 && out_q.size() == 0 && !stall_out && !dmem_req) break;
      if (dmem_req) begin
        req_cycles++;
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected: dmem_req=%b required 0", dmem_req);
          dmem_ready = 1'b1;
        end else begin
          t = tx_q[0];
          if (dmem_we !== t.we || dmem_addr !== t.addr ||
              (t.we && dmem_wdata !== t.wdata)) begin
            failures++;
            $display("FAIL dmem_req: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     dmem_we, dmem_addr, dmem_wdata, t.we, t.addr, t.wdata);
          end
          if (abort_at == done) begin
            reset = 1'b1; dmem_ready = 1'b0;
            aborted = 1'b1;
            break;
          end
          if (wait_cnt == 0) cur_delay = (delay < 0) ? int'($urandom_range(0, 2)) : delay;
          if (wait_cnt >= cur_delay) begin
            dmem_ready = 1'b1;
            dmem_rdata = mem_rd(t.addr);
            if (t.we) mem[t.addr] = t.wdata;
            void'(tx_q.pop_front());
            done++;
            wait_cnt = 0;
          end else begin
            dmem_ready = 1'b0;
            dmem_rdata = 16'($urandom);
            wait_cnt++;
          end
        end
      end else begin
        // ready without a request must be ignored
        dmem_ready = 1'($urandom);
        dmem_rdata = 16'($urandom);
      end
      @(negedge clk);
      budget++;
    end
    dmem_ready = 1'b0;
    if (budget >= 300) begin
      failures++;
      $display("FAIL timeout: instruction op=%b did not retire in %0d cycles", op, budget);
      tx_q.delete(); out_q.delete();
    end
    if (aborted) begin
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (dmem_req !== 1'b0 || out_valid !== 1'b0 || stall_out !== 1'b0) begin
        failures++;
        $display("FAIL abort_state: got req=%b valid=%b stall=%b required 0 0 0",
                 dmem_req, out_valid, stall_out);
      end
      tx_q.delete(); out_q.delete();
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL abort_quiet: got req=%b valid=%b required 0 0", dmem_req, out_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_op = {OP_ADD, 2'b00};
    in_alu_out = 16'hFFFF; in_ra_data = 16'h0; in_dest = 3'd7;
    in_reg_write = 1'b1; in_ccr_write = 1'b1; in_ccr_value = 2'b11;
    in_imm8 = 8'h0; dmem_ready = 1'b0; dmem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_wdata !== 16'h0 || out_reg_write !== 1'b0 ||
        out_ccr_write !== 1'b0 || out_zero_write !== 1'b0 || dmem_req !== 1'b0 ||
        stall_out !== 1'b0 || rf_rd_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b wdata=%h rw=%b ccrw=%b zw=%b req=%b stall=%b rfa=%0d required all 0",
               out_valid, out_wdata, out_reg_write, out_ccr_write, out_zero_write,
               dmem_req, stall_out, rf_rd_addr);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    int rc;
    run_instr(OP_ADD, 16'h1234, 16'h0, 3'd3, 1'b1, 1'b1, 2'b01, 8'h00, 0, -1, rc);
    for (int n = 0; n < 10; n++) begin
      logic [3:0] op;
      do op = 4'($urandom); while (is_mem_op(op));
      run_instr(op, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                1'($urandom), 2'($urandom), 8'($urandom), 0, -1, rc);
    end
  endtask

  task automatic test_lw();
    int rc;
    mem[16'h0040] = 16'h0000;
    run_instr(OP_LW, 16'h0040, 16'h0, 3'd5, 1'b1, 1'b1, 2'b11, 8'h00, 3, -1, rc);
    checks++;
    if (rc !== 4) begin
      failures++;
      $display("FAIL lw_req_cycles: got %0d required 4", rc);
    end
    for (int n = 0; n < 6; n++)
      run_instr(OP_LW, 16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 1'b0,
                2'b00, 8'($urandom), -1, -1, rc);
  endtask

  task automatic test_sw();
    int rc;
    run_instr(OP_SW, 16'h0010, 16'hBEEF, 3'd2, 1'b0, 1'b0, 2'b00, 8'h00, 0, -1, rc);
    checks++;
    if (rc !== 1) begin
      failures++;
      $display("FAIL sw_req_cycles: got %0d required 1", rc);
    end
    // read it back through the DUT
    run_instr(OP_LW, 16'h0010, 16'h0, 3'd6, 1'b1, 1'b0, 2'b00, 8'h00, -1, -1, rc);
  endtask

  task automatic test_lm_wrap();
    int rc;
    mem[16'hFFFE] = 16'hA001; mem[16'hFFFF] = 16'hA002; mem[16'h0000] = 16'hA003;
    run_instr(OP_LM, 16'hFFFE, 16'h0, 3'd0, 1'b0, 1'b0, 2'b00, 8'h85, -1, -1, rc);
    checks++;
    if (rc < 3) begin
      failures++;
      $display("FAIL lm_req_cycles: got %0d required at least 3", rc);
    end
  endtask

  task automatic test_sm();
    int rc;
    run_instr(OP_SM, 16'h0200, 16'h0, 3'd0, 1'b0, 1'b0, 2'b00, 8'h00, 0, -1, rc);
    checks++;
    if (rc !== 0) begin
      failures++;
      $display("FAIL sm_empty_req: got %0d required 0", rc);
    end
    rf[1] = 16'h1111; rf[3] = 16'h3333;
    run_instr(OP_SM, 16'h0300, 16'h0, 3'd0, 1'b0, 1'b0, 2'b00, 8'h0A, -1, -1, rc);
    checks++;
    if (mem_rd(16'h0300) !== 16'h1111 || mem_rd(16'h0301) !== 16'h3333) begin
      failures++;
      $display("FAIL sm_mem: got %h %h required 1111 3333", mem_rd(16'h0300), mem_rd(16'h0301));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [6];
    logic [2:0]  exp_d [6];
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_wdata !== exp_w[i-1] || out_dest !== exp_d[i-1] ||
            stall_out !== 1'b0) begin
          failures++;
          $display("FAIL back_to_back: got valid=%b wdata=%h dest=%0d stall=%b required 1 %h %0d 0",
                   out_valid, out_wdata, out_dest, stall_out, exp_w[i-1], exp_d[i-1]);
        end
      end
      if (i < 6) begin
        exp_w[i] = 16'($urandom); exp_d[i] = 3'($urandom);
        in_valid = 1'b1; in_op = {4'b0001, 2'b10}; in_alu_out = exp_w[i];
        in_dest = exp_d[i]; in_reg_write = 1'b1; in_ccr_write = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int rc;
    for (int n = 0; n < 30; n++) begin
      for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
      run_instr(4'($urandom), 16'($urandom_range(0, 15)) + 16'hFFF8,
                16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 8'($urandom), -1, -1, rc);
    end
  endtask

  task automatic test_reset_mid_lm();
    int rc;
    run_instr(OP_LM, 16'h0500, 16'h0, 3'd0, 1'b0, 1'b0, 2'b00, 8'hB6, -1, 1, rc);
    // stage is usable again after the abort
    run_instr(OP_ADD, 16'h7777, 16'h0, 3'd4, 1'b1, 1'b0, 2'b00, 8'h00, 0, -1, rc);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) rf[r] = 16'h1000 + 16'(r);
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_lm_wrap();
    test_sm();
    test_back_to_back();
    test_random();
    test_reset_mid_lm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the pipelined RISC15 core. Sits directly downstream of the execute stage: it consumes the EX/MEM pipeline register (ALU result, store data, destination, CCR update) and produces the MEM/WB register contents.
- Performs single-word LW/SW through a handshaked data-memory port.
- Sequences multi-cycle LM/SM transfers from the 8-bit register list, stalling upstream while busy.
- Passes non-memory ops through with one cycle of latency.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  EX/MEM register holds a valid instruction.
- in_op  in  6  {IR[15:12],IR[1:0]}; only [5:2] is decoded here. LW=0100, SW=0101, LM=0110, SM=0111; all others are non-memory ops.
- in_alu_out  in  16  effective address for memory ops; result for ALU ops.
- in_ra_data  in  16  store data for SW.
- in_dest  in  3  destination register.
- in_reg_write  in  1  register write enable.
- in_ccr_write  in  1  CCR write enable from execute.
- in_ccr_value  in  2  {zero,carry} from execute.
- in_imm8  in  8  LM/SM register list; bit k selects Rk.
- stall_out  out  1  upstream must hold its register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  16  memory address.
- dmem_wdata  out  16  memory write data.
- dmem_rdata  in  16  memory read data, valid with dmem_ready.
- dmem_ready  in  1  request completes this cycle.
- rf_rd_addr  out  3  register-file read port used by SM.
- rf_rd_data  in  16  combinational read data for rf_rd_addr.
- out_valid  out  1  MEM/WB register holds a valid entry.
- out_dest  out  3  writeback register.
- out_wdata  out  16  writeback data.
- out_reg_write  out  1  writeback enable.
- out_ccr_write  out  1  write both CCR flags.
- out_ccr_value  out  2  {zero,carry}.
- out_zero_write  out  1  write only the zero flag (LW).
- out_zero_value  out  1  zero flag value.

Behaviour:
Reset:
- Synchronous, active-high; takes priority over all other actions.
- State returns to IDLE; the list register and address register clear.
- All out_* are 0; dmem_req = 0; stall_out = 0.
- Reset mid-transfer aborts: no further dmem_req and no out_valid for the aborted instruction.

State machine:
- States are IDLE, ACCESS and MULTI.
- stall_out = (state != IDLE).
- Inputs are sampled only in IDLE, on a clk edge with in_valid = 1.
- Entering ACCESS or MULTI on that edge raises stall_out in the following cycle.

IDLE, on accepting an instruction:
- Non-memory op: register it to out_* on the next edge. out_valid = 1 and out_wdata = in_alu_out; out_dest, out_reg_write, out_ccr_write and out_ccr_value are copied. Latency 1.
- LW or SW: capture address and data, then go to ACCESS.
- LM or SM with in_imm8 != 0: load the list register and set addr = in_alu_out, then go to MULTI.
- LM or SM with in_imm8 == 0: behave as a NOP. out_valid = 1 with all write enables 0; stay in IDLE.
- in_valid = 0: out_valid = 0 on the next edge.

Handshake:
- dmem_req, dmem_we, dmem_addr and dmem_wdata are registered or state-derived.
- Once dmem_req is raised, all four stay stable until the cycle in which dmem_ready = 1.
- dmem_ready while dmem_req = 0 is ignored.

ACCESS:
- dmem_req = 1.
- On dmem_ready:
  - SW: out_valid = 1 with all enables 0.
  - LW: out_valid = 1, out_wdata = dmem_rdata, out_dest = in_dest, out_reg_write = 1, out_zero_write = 1, out_zero_value = (dmem_rdata == 0), out_ccr_write = 0.
- Outputs appear on the edge ending the ready cycle; the state returns to IDLE on the same edge.
- In every other cycle out_valid = 0.

MULTI:
- k = index of the lowest set bit of the list register.
- dmem_addr = addr.
- LM: dmem_we = 0.
- SM: dmem_we = 1, rf_rd_addr = k, dmem_wdata = rf_rd_data.
- On dmem_ready:
  - LM: emit out_valid = 1 with out_dest = k, out_wdata = dmem_rdata and out_reg_write = 1; no CCR update.
  - SM: emit out_valid = 1 with no enables.
  - Clear bit k. addr = addr + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - If the remaining list is 0, go to IDLE; otherwise issue the next transfer in the next cycle. dmem_req may stay high back-to-back.
- Transfers proceed in ascending register order. Each listed register is transferred exactly once.
- rf_rd_addr = 0 outside MULTI.

Test Plan:
- ADD with in_alu_out=0x1234, dest=3, ccr_write=1, value=2'b01 -> one cycle later out_valid=1, out_wdata=0x1234, out_dest=3, out_ccr_write=1, out_ccr_value=01, stall_out=0.
- LW addr=0x0040, dmem_ready delayed 3 cycles, rdata=0x0000 -> dmem_req held with addr 0x0040 for 4 cycles, stall_out=1, then out_wdata=0, out_zero_write=1, out_zero_value=1, out_reg_write=1.
- SW addr=0x0010, ra_data=0xBEEF, immediate ready -> one write with we=1, addr 0x0010, wdata 0xBEEF; out_reg_write=0.
- LM base=0xFFFE, imm8=0x85 -> reads at 0xFFFE, 0xFFFF and 0x0000 write R0, R2 and R7 in that order; stall_out stays high until the last ready.
- SM imm8=0x00 -> no dmem_req, NOP output, no stall. SM imm8=0x0A with R1=0x1111, R3=0x3333 -> writes 0x1111@base, 0x3333@base+1.
- Reset asserted during the 2nd LM transfer -> next cycle dmem_req=0, out_valid=0, stall_out=0, and the remaining registers are never written.
